// File: rtl/vending_machine.sv
// Single-product (Rs 40) coin-credit vending controller with one-cycle vend pulse and change report.
// Optional build macro VM_COIN10_EN enables coin code 2'b11 as a Rs 10 coin.
module vending_machine (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] coin,
  output logic       Z,
  output logic       Change_given,
  output logic [7:0] Change_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_C10  = 3'd1;
  localparam logic [2:0] S_C20  = 3'd2;
  localparam logic [2:0] S_C30  = 3'd3;
  localparam logic [2:0] S_VEND = 3'd4;

  localparam logic [7:0] PRICE = 8'd40;

  logic [2:0] state_q, state_d;
  logic       z_q, z_d;
  logic       change_given_q, change_given_d;
  logic [7:0] change_out_q, change_out_d;
  logic [7:0] coin_val;
  logic [7:0] sum;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = 8'd20;
      2'b10:   coin_value = 8'd50;
`ifdef VM_COIN10_EN
      2'b11:   coin_value = 8'd10;
`else
      2'b11:   coin_value = 8'd0;
`endif
      default: coin_value = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] credit_of(input logic [2:0] st);
    case (st)
      S_C10:   credit_of = 8'd10;
      S_C20:   credit_of = 8'd20;
      S_C30:   credit_of = 8'd30;
      default: credit_of = 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] state_for(input logic [7:0] credit);
    case (credit)
      8'd10:   state_for = S_C10;
      8'd20:   state_for = S_C20;
      8'd30:   state_for = S_C30;
      default: state_for = S_IDLE;
    endcase
  endfunction

  // Next-state and registered-output computation; outputs default to zero outside VEND.
  always_comb begin
    state_d        = state_q;
    z_d            = 1'b0;
    change_given_d = 1'b0;
    change_out_d   = 8'd0;
    coin_val       = coin_value(coin);
    sum            = credit_of(state_q) + coin_val;
    case (state_q)
      S_IDLE, S_C10, S_C20, S_C30: begin
        if (coin_val == 8'd0) begin
          state_d = state_q;
        end else if (sum >= PRICE) begin
          state_d        = S_VEND;
          z_d            = 1'b1;
          change_out_d   = sum - PRICE;
          change_given_d = (sum != PRICE);
        end else begin
          state_d = state_for(sum);
        end
      end
      // Coins arriving during the vend cycle are dropped, not credited.
      S_VEND:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      z_q            <= 1'b0;
      change_given_q <= 1'b0;
      change_out_q   <= 8'd0;
    end else begin
      state_q        <= state_d;
      z_q            <= z_d;
      change_given_q <= change_given_d;
      change_out_q   <= change_out_d;
    end
  end

  assign Z            = z_q;
  assign Change_given = change_given_q;
  assign Change_out   = change_out_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine; expectations adapt to the VM_COIN10_EN build.
module tb_vending_machine;

  logic       CLK;
  logic       RESET;
  logic [1:0] coin;
  logic       Z;
  logic       Change_given;
  logic [7:0] Change_out;

  int n_checks;
  int n_errors;

  vending_machine dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .coin         (coin),
    .Z            (Z),
    .Change_given (Change_given),
    .Change_out   (Change_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present a coin code for one rising edge, then sample 1 time unit later.
  task automatic tick(input logic [1:0] c);
    coin = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic z_exp, input logic cg_exp, input logic [7:0] co_exp);
    n_checks++;
    assert (Z === z_exp) else begin
      n_errors++;
      $error("FAIL %s Z: observed %0b expected %0b", tag, Z, z_exp);
    end
    n_checks++;
    assert (Change_given === cg_exp) else begin
      n_errors++;
      $error("FAIL %s Change_given: observed %0b expected %0b", tag, Change_given, cg_exp);
    end
    n_checks++;
    assert (Change_out === co_exp) else begin
      n_errors++;
      $error("FAIL %s Change_out: observed %0d expected %0d", tag, Change_out, co_exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET    = 1'b1;
    coin     = 2'b01;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_hold", 1'b0, 1'b0, 8'd0);
    RESET = 1'b0;
    coin  = 2'b00;

    // 20 + 20: exact price, no change
    tick(2'b01); check("c20", 1'b0, 1'b0, 8'd0);
    tick(2'b01); check("vend_exact", 1'b1, 1'b0, 8'd0);
    tick(2'b00); check("after_vend_exact", 1'b0, 1'b0, 8'd0);

    // 50 from IDLE: change 10
    tick(2'b10); check("vend_50", 1'b1, 1'b1, 8'd10);
    tick(2'b00); check("after_vend_50", 1'b0, 1'b0, 8'd0);

    // 11, 01, 01
    tick(2'b11); check("code11_first", 1'b0, 1'b0, 8'd0);
    tick(2'b01); check("code11_second", 1'b0, 1'b0, 8'd0);
    tick(2'b01);
`ifdef VM_COIN10_EN
    check("code11_vend", 1'b1, 1'b1, 8'd10);
`else
    check("code11_vend", 1'b1, 1'b0, 8'd0);
`endif
    tick(2'b00); check("code11_after", 1'b0, 1'b0, 8'd0);

    // Maximum change path: 11, 01, 10 then a coin during VEND
    tick(2'b11); check("max_first", 1'b0, 1'b0, 8'd0);
    tick(2'b01); check("max_second", 1'b0, 1'b0, 8'd0);
    tick(2'b10);
`ifdef VM_COIN10_EN
    check("max_vend", 1'b1, 1'b1, 8'd40);
`else
    check("max_vend", 1'b1, 1'b1, 8'd30);
`endif
    tick(2'b01); check("coin_in_vend", 1'b0, 1'b0, 8'd0);
    tick(2'b01); check("post_vend_c20", 1'b0, 1'b0, 8'd0);
    tick(2'b01); check("post_vend_vend", 1'b1, 1'b0, 8'd0);
    tick(2'b00); check("post_vend_idle", 1'b0, 1'b0, 8'd0);

    // Reset during VEND clears outputs without a clock edge
    tick(2'b10); check("pre_reset_vend", 1'b1, 1'b1, 8'd10);
    coin = 2'b00;
    #2 RESET = 1'b1;
    #1 check("reset_in_vend", 1'b0, 1'b0, 8'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset mid-accumulation discards credit; coins ignored while held
    tick(2'b01); check("pre_reset_c20", 1'b0, 1'b0, 8'd0);
    coin = 2'b01;
    #2 RESET = 1'b1;
    #1 check("reset_mid_acc", 1'b0, 1'b0, 8'd0);
    @(posedge CLK);
    #1 check("reset_held_coin", 1'b0, 1'b0, 8'd0);
    RESET = 1'b0;
    tick(2'b01); check("after_reset_c20", 1'b0, 1'b0, 8'd0);
    tick(2'b01); check("after_reset_vend", 1'b1, 1'b0, 8'd0);
    tick(2'b00); check("after_reset_idle", 1'b0, 1'b0, 8'd0);

    // Idle stability
    for (int i = 0; i < 10; i++) begin
      tick(2'b00);
      check("idle_stable", 1'b0, 1'b0, 8'd0);
    end
    tick(2'b01); check("idle_then_c20", 1'b0, 1'b0, 8'd0);
    tick(2'b01); check("idle_then_vend", 1'b1, 1'b0, 8'd0);
    tick(2'b00); check("final_idle", 1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
# vending_machine

Coin-operated vending controller for a single product priced at ₹40. It accumulates coin credit across clock cycles and issues a one-cycle vend pulse once credit reaches or exceeds the price. Any excess is reported as change in rupees. It sits between the coin-acceptor decoder, which supplies one 2-bit coin code per cycle, and the dispense/refund actuators, which consume Z, Change_given and Change_out.

## Interface
- Parameters: none; price (₹40) and coin values are fixed.
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- coin  input  2  coin code sampled each rising edge:
  - 00: no coin
  - 01: ₹20
  - 10: ₹50
  - 11: ₹10 (see Configuration)
- Z  output  1  product-dispense pulse, registered.
- Change_given  output  1  high in the vend cycle when change is non-zero, registered.
- Change_out  output  8  change amount in rupees (unsigned); valid when Z=1, otherwise 0.

## Operation
- States:
  - IDLE: credit ₹0.
  - C10: credit ₹10.
  - C20: credit ₹20.
  - C30: credit ₹30.
  - VEND: one-cycle dispense state.
- In IDLE/C10/C20/C30, at each rising edge, sum = credit + value(coin):
  - sum < 40: move to the credit state for that sum.
  - sum ≥ 40: move to VEND, load Z=1, Change_out = sum − 40, Change_given = (sum − 40 ≠ 0).
  - coin=00: no change of state.
- VEND always returns to IDLE on the next edge. Z, Change_given and Change_out return to 0 there.
- Coin codes presented while in VEND are ignored (not credited).
- Arithmetic:
  - The largest sum is 30+50 = 80, so the largest change is ₹40. An 8-bit width is sufficient; no saturation is needed.
  - Change_out upper bits are zero.
- Outputs are 0 in all states except VEND.
- Reset:
  - Asserting RESET at any time, including mid-accumulation or during VEND, forces state IDLE and clears Z, Change_given and Change_out to 0 immediately, independent of CLK.
  - Accumulated credit is discarded; no change is issued for it.
- While RESET is held high, coin inputs are ignored.

## Timing
- Coin sampled on rising edge N; Z/Change outputs high during cycle N+1 (one-edge latency from the completing coin), for exactly one clock cycle.
- One coin per cycle. Consecutive non-zero codes in consecutive cycles are each credited, so no idle cycle is required between coins.
- First edge after RESET deasserts samples coin normally.
- Reset values:
  - state: IDLE
  - Z: 0
  - Change_given: 0
  - Change_out: 8'd0

## Configuration
- VM_COIN10_EN:
  - Defined: code 11 is accepted as a ₹10 coin per the transition rules above.
  - Not defined: code 11 is treated exactly as 00 (no credit, no state change).
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then coin 01, 01, 00 on successive edges -> Z=1, Change_given=0, Change_out=0 for one cycle after the second edge; back to IDLE with outputs 0 thereafter.
- Reset, coin 10 then 00 -> one-cycle Z=1, Change_given=1, Change_out=10.
- VM_COIN10_EN defined: reset, coin 11, 01, 01 -> state C10, C30, then VEND with Z=1, Change_given=1, Change_out=10. Without the macro, the same sequence yields C20 then VEND with Change_out=0.
- Maximum change: coin 11, 01 (C30, macro on), then 10 -> Z=1, Change_out=40; a coin 01 applied during the VEND cycle is not credited (state IDLE afterwards).
- Mid-transaction reset: coin 01 (C20), assert RESET between edges -> Z/Change outputs 0 immediately, state IDLE. After release, coin 01 alone gives no vend and state is C20.
- Idle stability: 10 cycles of coin 00 in IDLE -> no state change, all outputs 0.
